// File: rtl/axis_packetizer.sv
// AXI-Stream packetizer: cuts an unframed stream into packets of pkt_length beats
// (or shorter on flush). Define AXIS_PACKETIZER_TUSER_SOF_EN to mark first beats on m_axis_tuser.
module axis_packetizer #(
    parameter int TDATA_WIDTH    = 32,
    parameter int MAX_PKT_LENGTH = 4096,
    localparam int LW            = $clog2(MAX_PKT_LENGTH) + 1
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic [LW-1:0]          pkt_length,
    input  logic                   flush,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    output logic [LW-1:0]          beat_cnt,
    output logic [31:0]            pkt_cnt,
    output logic [0:0]             dbg_state
);

    // Handshakes: a beat moves on a port in a cycle where valid and ready are
    // both high at the rising edge; valid never waits on ready, and master
    // payload holds steady while valid is high and ready is low.

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_PKT = 1'b1;

    localparam int PW = TDATA_WIDTH + 2;
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PKT_LENGTH);

    logic [0:0]    state;
    logic [LW-1:0] len_q;
    logic          flush_pend;
    logic [LW-1:0] len_in;
    logic [LW-1:0] cur_len;
    logic          in_last;
    logic          in_sof;
    logic          acc;
    logic          m_fire;

    logic          s_ready_q;
    logic          m_valid_q;
    logic [PW-1:0] m_pay_q;
    logic          sk_valid_q;
    logic          sk_valid_d;
    logic [PW-1:0] sk_pay_q;
    logic [PW-1:0] in_pay;

    assign acc    = s_axis_tvalid && s_ready_q;
    assign m_fire = m_valid_q && m_axis_tready;

    always_comb begin
        len_in = pkt_length;
        if (pkt_length == '0) begin
            len_in = LW'(1);
        end else if (pkt_length > MAX_LEN) begin
            len_in = MAX_LEN;
        end
    end

    // The first beat of a packet uses the live pkt_length; later beats use the latched copy.
    assign cur_len = (state == ST_IDLE) ? len_in : len_q;
    assign in_last = ((beat_cnt + LW'(1)) == cur_len) || flush || flush_pend;

`ifdef AXIS_PACKETIZER_TUSER_SOF_EN
    assign in_sof = (state == ST_IDLE);
`else
    assign in_sof = 1'b0;
`endif

    assign in_pay = {in_sof, in_last, s_axis_tdata};

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            len_q      <= LW'(1);
            flush_pend <= 1'b0;
            pkt_cnt    <= '0;
        end else begin
            if (acc) begin
                flush_pend <= 1'b0;
                if (state == ST_IDLE) begin
                    len_q <= len_in;
                end
                if (in_last) begin
                    beat_cnt <= '0;
                    state    <= ST_IDLE;
                end else begin
                    beat_cnt <= beat_cnt + LW'(1);
                    state    <= ST_IN_PKT;
                end
            end else if (flush && (state == ST_IN_PKT)) begin
                flush_pend <= 1'b1;
            end
            if (m_fire && m_axis_tlast) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

    // The skid entry only fills when the output register is stalled, so the
    // input can be accepted without looking at m_axis_tready this cycle.
    always_comb begin
        sk_valid_d = sk_valid_q;
        if (m_fire || !m_valid_q) begin
            sk_valid_d = 1'b0;
        end else if (acc) begin
            sk_valid_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_pay_q    <= '0;
            sk_valid_q <= 1'b0;
            sk_pay_q   <= '0;
        end else begin
            sk_valid_q <= sk_valid_d;
            s_ready_q  <= !sk_valid_d;
            if (m_fire || !m_valid_q) begin
                if (sk_valid_q) begin
                    m_valid_q <= 1'b1;
                    m_pay_q   <= sk_pay_q;
                end else if (acc) begin
                    m_valid_q <= 1'b1;
                    m_pay_q   <= in_pay;
                end else begin
                    m_valid_q <= 1'b0;
                end
            end else if (acc) begin
                sk_pay_q <= in_pay;
            end
        end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_pay_q[TDATA_WIDTH-1:0];
    assign m_axis_tlast  = m_pay_q[PW-2];
    assign m_axis_tuser  = m_pay_q[PW-1];
    assign dbg_state     = state;

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer: expected beats queued by the driver, checked at the master port.
module tb_axis_packetizer;
    localparam int TDATA_WIDTH    = 32;
    localparam int MAX_PKT_LENGTH = 4096;
    localparam int LW             = $clog2(MAX_PKT_LENGTH) + 1;
    localparam int PW             = TDATA_WIDTH + 2;

    logic                   aclk;
    logic                   resetn;
    logic [LW-1:0]          pkt_length;
    logic                   flush;
    logic                   s_axis_tvalid;
    logic                   s_axis_tready;
    logic [TDATA_WIDTH-1:0] s_axis_tdata;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic [TDATA_WIDTH-1:0] m_axis_tdata;
    logic                   m_axis_tlast;
    logic                   m_axis_tuser;
    logic [LW-1:0]          beat_cnt;
    logic [31:0]            pkt_cnt;
    logic [0:0]             dbg_state;

    axis_packetizer #(
        .TDATA_WIDTH   (TDATA_WIDTH),
        .MAX_PKT_LENGTH(MAX_PKT_LENGTH)
    ) dut (
        .aclk         (aclk),
        .resetn       (resetn),
        .pkt_length   (pkt_length),
        .flush        (flush),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .beat_cnt     (beat_cnt),
        .pkt_cnt      (pkt_cnt),
        .dbg_state    (dbg_state)
    );

    logic [PW-1:0] exp_q[$];
    int            hs_cyc[$];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            rdy_mode = 1;
    int            acc_cyc  = 0;
    logic [31:0]   seq      = 32'h1000;
    logic          stall_prev = 1'b0;
    logic [PW-1:0] stall_pay  = '0;

    // clock / reset
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic report();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_user(input logic sof);
`ifdef AXIS_PACKETIZER_TUSER_SOF_EN
        return sof;
`else
        return 1'b0 & sof;
`endif
    endfunction

    // master ready: 0 = held low, 1 = held high, 2 = random 50%
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // scoreboard / monitor
    always @(negedge aclk) begin
        if (!resetn) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check("stable_valid", 64'(m_axis_tvalid), 64'd1);
                check("stable_payload", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'(stall_pay));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs_cyc.push_back(cyc);
                check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    logic [PW-1:0] e;
                    e = exp_q.pop_front();
                    check("out_data", 64'(m_axis_tdata), 64'(e[TDATA_WIDTH-1:0]));
                    check("out_last", 64'(m_axis_tlast), 64'(e[PW-2]));
                    check("out_user", 64'(m_axis_tuser), 64'(e[PW-1]));
                end
            end
            stall_prev <= m_axis_tvalid && !m_axis_tready;
            stall_pay  <= {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        end
    end

    // driver tasks
    task automatic send(input logic last, input logic sof, input logic fl);
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = seq;
        flush         = fl;
        @(negedge aclk);
        while (!s_axis_tready && n < 200) begin
            n++;
            @(negedge aclk);
        end
        if (!s_axis_tready) begin
            check("s_accept_timeout", 64'(s_axis_tready), 64'd1);
            report();
        end
        acc_cyc = cyc;
        exp_q.push_back({exp_user(sof), last, seq});
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        flush         = 1'b0;
        seq           = seq + 32'd1;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge aclk);
        #1;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 20000) begin
            n++;
            @(negedge aclk);
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        idle(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, "_s_ready"}, 64'(s_axis_tready), 64'd0);
        check({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
        check({tag, "_tuser"}, 64'(m_axis_tuser), 64'd0);
        check({tag, "_tdata"}, 64'(m_axis_tdata), 64'd0);
        check({tag, "_beat_cnt"}, 64'(beat_cnt), 64'd0);
        check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog obs=time_expired exp=finished");
        report();
    end

    initial begin
        int i0;
        int a0;
        resetn        = 1'b0;
        pkt_length    = LW'(4);
        flush         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;

        // reset state
        idle(3);
        check_reset_outputs("rst");
        resetn = 1'b1;
        idle(1);
        check("rst_release_s_ready", 64'(s_axis_tready), 64'd1);

        // 12 back-to-back beats, length 4
        rdy_mode   = 1;
        pkt_length = LW'(4);
        idle(2);
        i0 = hs_cyc.size();
        a0 = 0;
        for (int i = 1; i <= 12; i++) begin
            send(i % 4 == 0, i % 4 == 1, 1'b0);
            if (i == 1) a0 = acc_cyc;
        end
        wait_drain();
        check("t4_pkt_cnt", 64'(pkt_cnt), 64'd3);
        check("t4_beats", 64'(hs_cyc.size() - i0), 64'd12);
        if (hs_cyc.size() >= i0 + 12) begin
            check("t4_latency", 64'(hs_cyc[i0] - a0), 64'd1);
            check("t4_no_bubble", 64'(hs_cyc[i0+11] - hs_cyc[i0]), 64'd11);
        end

        // flush alone after beat 3 of an 8-beat packet
        pkt_length = LW'(8);
        send(1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        check("fl_beat_cnt3", 64'(beat_cnt), 64'd3);
        check("fl_state_in_pkt", 64'(dbg_state), 64'd1);
        flush_pulse();
        check("fl_beat_cnt_hold", 64'(beat_cnt), 64'd3);
        idle(2);
        send(1'b1, 1'b0, 1'b0);
        check("fl_beat_cnt0", 64'(beat_cnt), 64'd0);
        check("fl_state_idle", 64'(dbg_state), 64'd0);
        // flush while idle is ignored; mid-packet length change has no effect
        flush_pulse();
        for (int i = 1; i <= 8; i++) begin
            send(i == 8, i == 1, 1'b0);
            if (i == 1) pkt_length = LW'(3);
        end
        pkt_length = LW'(8);
        wait_drain();
        check("fl_pkt_cnt", 64'(pkt_cnt), 64'd5);

        // flush coinciding with the natural last beat
        pkt_length = LW'(2);
        send(1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        flush_pulse();
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        wait_drain();
        check("co_pkt_cnt", 64'(pkt_cnt), 64'd9);

        // length clamps: 0 -> 1 beat; 70000 truncates to 4464, still above 4096
        pkt_length = LW'(0);
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        pkt_length = 13'(70000);
        for (int i = 1; i <= 4096; i++) begin
            send(i == 4096, i == 1, 1'b0);
        end
        wait_drain();
        check("cl_pkt_cnt", 64'(pkt_cnt), 64'd12);
        check("cl_beat_cnt", 64'(beat_cnt), 64'd0);

        // random backpressure and source gaps, length 5
        pkt_length = LW'(5);
        rdy_mode   = 2;
        for (int i = 1; i <= 1000; i++) begin
            idle($urandom_range(0, 1));
            send(i % 5 == 0, i % 5 == 1, 1'b0);
        end
        wait_drain();
        rdy_mode = 1;
        check("rnd_pkt_cnt", 64'(pkt_cnt), 64'd212);

        // reset in the middle of a 6-beat packet with beats buffered
        rdy_mode   = 0;
        pkt_length = LW'(6);
        idle(2);
        send(1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        check("mr_beat_cnt2", 64'(beat_cnt), 64'd2);
        resetn = 1'b0;
        idle(1);
        check_reset_outputs("mr");
        exp_q.delete();
        resetn = 1'b1;
        idle(1);
        check("mr_release_s_ready", 64'(s_axis_tready), 64'd1);
        check("mr_release_m_valid", 64'(m_axis_tvalid), 64'd0);
        rdy_mode = 1;
        for (int i = 1; i <= 6; i++) begin
            send(i == 6, i == 1, 1'b0);
        end
        wait_drain();
        check("mr_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // start-of-packet marking, length 3
        pkt_length = LW'(3);
        for (int i = 1; i <= 9; i++) begin
            send(i % 3 == 0, i % 3 == 1, 1'b0);
        end
        wait_drain();
        check("sof_pkt_cnt", 64'(pkt_cnt), 64'd4);

        report();
    end
endmodule

// File: doc/axis_packetizer.md
AXIS_PACKETIZER -- requirements
Module: axis_packetizer

Interface
REQ-001 Parameter TDATA_WIDTH, default 32: data bus width in bits, 8..1024.
REQ-002 Parameter MAX_PKT_LENGTH, default 4096: largest packet in beats, 2..65536; LW = $clog2(MAX_PKT_LENGTH)+1.
REQ-003 aclk  input  1  clock; all logic rising-edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 pkt_length  input  LW  requested beats per packet, sampled per packet.
REQ-006 flush  input  1  force early packet termination.
REQ-007 s_axis_tvalid / s_axis_tready / s_axis_tdata  input / output / input  1 / 1 / TDATA_WIDTH  AXI-Stream slave, no tlast.
REQ-008 m_axis_tvalid / m_axis_tready / m_axis_tdata / m_axis_tlast  output / input / output / output  1 / 1 / TDATA_WIDTH / 1  AXI-Stream master.
REQ-009 m_axis_tuser  output  1  start-of-packet marker.
REQ-010 beat_cnt  output  LW  beats accepted so far in the current input packet.
REQ-011 pkt_cnt  output  32  packets completed on the master side.

Function
REQ-012 Output path: registered two-entry skid buffer; input beat appears on master no earlier than the cycle after acceptance; sustains 1 beat/cycle when m_axis_tready is held high.
REQ-013 s_axis_tready: registered, high iff the skid entry is empty; never combinationally dependent on m_axis_tready.
REQ-014 Data, tlast and tuser held stable while m_axis_tvalid=1 and m_axis_tready=0 (AXI-Stream rule).
REQ-015 pkt_length latched into len_q on the first accepted beat of each packet; changes mid-packet have no effect on the current packet.
REQ-016 Length clamp: a latched value of 0 is treated as 1; a latched value > MAX_PKT_LENGTH is treated as MAX_PKT_LENGTH.
REQ-017 beat_cnt: 0 at packet start; +1 per accepted input beat; returns to 0 in the cycle after the last beat of a packet is accepted.
REQ-018 tlast is attached to the accepted beat for which beat_cnt+1 == len_q.
REQ-019 flush high in a cycle with an accepted beat: that beat carries tlast.
REQ-020 flush high with no accepted beat: a pending flag is set and the next accepted beat carries tlast; the flag clears on that beat.
REQ-021 flush while beat_cnt==0 and no beat pending: ignored, so no empty packets are produced.
REQ-022 Flush coinciding with a natural length tlast: exactly one tlast; the pending flag is cleared.
REQ-023 pkt_cnt: +1 on each master handshake with m_axis_tlast=1; wraps 2^32-1 -> 0.
REQ-024 Control is two states: IDLE (beat_cnt==0) and IN_PKT. IDLE->IN_PKT on an accepted non-last beat; IN_PKT->IDLE on an accepted tlast beat; IDLE->IDLE on an accepted single-beat packet.

Reset
REQ-025 While resetn=0: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, s_axis_tready=0, beat_cnt=0, pkt_cnt=0, state IDLE, flush pending cleared, skid entries emptied.
REQ-026 s_axis_tready=1 in the first cycle after resetn returns high.
REQ-027 Reset mid-packet discards all buffered beats; the next accepted beat starts a new packet.

Configuration
REQ-028 Macro AXIS_PACKETIZER_TUSER_SOF_EN defined: m_axis_tuser=1 on the first beat of every packet and 0 otherwise.
REQ-029 Macro absent: m_axis_tuser is tied to 0; the port remains present; all other behaviour is unchanged.

Verification
REQ-030 pkt_length=4, 12 back-to-back beats, m_axis_tready=1 -> tlast on beats 4, 8, 12; pkt_cnt=3; no bubbles after the first-beat latency.
REQ-031 pkt_length=8, flush pulsed alone after beat 3, beat 4 sent later -> beat 4 carries tlast; the next packet is 8 beats.
REQ-032 pkt_length=0, then pkt_length=70000 with MAX_PKT_LENGTH=4096 -> packets of 1 beat and 4096 beats.
REQ-033 Random m_axis_tready (50%) and s_axis_tvalid, pkt_length=5, 1000 beats -> data order preserved, no loss or duplication, master signals stable under backpressure, pkt_cnt=200.
REQ-034 resetn low for 1 cycle at beat 3 of a 6-beat packet -> outputs match REQ-025; the following 6 beats form one complete packet.
REQ-035 With AXIS_PACKETIZER_TUSER_SOF_EN, pkt_length=3, 9 beats -> tuser=1 on beats 1, 4, 7 only; without the macro -> tuser=0 throughout.
